// File: rtl/arbiter.sv
// rtl/arbiter.sv - two-master / three-slave bus arbiter with serial slave addressing
module arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       slave_select,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       busy,
  output logic [1:0] bus_grant,
  output logic [2:0] slave_grant
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    ADDR0      = 3'd2,
    ADDR1      = 3'd3,
    CONNECTED  = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [1:0] addr_sr, addr_sr_next;
  logic       m1_grant_next, m2_grant_next, busy_next;
  logic [1:0] bus_grant_next;
  logic [2:0] slave_grant_next;
  logic       owner_request;
  logic [1:0] addr_full;

  // The current owner's request; the other master's request is never looked at while busy.
  assign owner_request = m1_grant ? m1_request : m2_request;

  // Full address at the ADDR1 edge: live bit is addr[1], shifted bit is addr[0].
  assign addr_full = {slave_select, addr_sr[1]};

  // State, address shift register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_sr     <= 2'b00;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      busy        <= 1'b0;
      bus_grant   <= 2'b00;
      slave_grant <= 3'b000;
    end else begin
      state       <= state_next;
      addr_sr     <= addr_sr_next;
      m1_grant    <= m1_grant_next;
      m2_grant    <= m2_grant_next;
      busy        <= busy_next;
      bus_grant   <= bus_grant_next;
      slave_grant <= slave_grant_next;
    end
  end

  // Next-state and next-output logic: arbitration in IDLE, frame decode while owned.
  always_comb begin
    state_next       = state;
    addr_sr_next     = addr_sr;
    m1_grant_next    = m1_grant;
    m2_grant_next    = m2_grant;
    bus_grant_next   = bus_grant;
    slave_grant_next = slave_grant;

    if (state == IDLE) begin
      slave_grant_next = 3'b000;
      addr_sr_next     = 2'b00;
      if (m1_request) begin
        state_next     = WAIT_START;
        m1_grant_next  = 1'b1;
        m2_grant_next  = 1'b0;
        bus_grant_next = 2'b01;
      end else if (m2_request) begin
        state_next     = WAIT_START;
        m1_grant_next  = 1'b0;
        m2_grant_next  = 1'b1;
        bus_grant_next = 2'b10;
      end else begin
        m1_grant_next  = 1'b0;
        m2_grant_next  = 1'b0;
        bus_grant_next = 2'b00;
      end
    end else if (!owner_request) begin
      // Release wins over any frame progress; the next owner is picked from IDLE.
      state_next       = IDLE;
      addr_sr_next     = 2'b00;
      m1_grant_next    = 1'b0;
      m2_grant_next    = 1'b0;
      bus_grant_next   = 2'b00;
      slave_grant_next = 3'b000;
    end else begin
      case (state)
        WAIT_START: begin
          if (slave_select) state_next = ADDR0;
        end
        ADDR0: begin
          addr_sr_next = {slave_select, addr_sr[1]};
          state_next   = ADDR1;
        end
        ADDR1: begin
          addr_sr_next = {slave_select, addr_sr[1]};
          state_next   = CONNECTED;
          case (addr_full)
            2'd0:    slave_grant_next = 3'b001;
            2'd1:    slave_grant_next = 3'b010;
            2'd2:    slave_grant_next = 3'b100;
            default: slave_grant_next = 3'b000;
          endcase
        end
        CONNECTED: begin
          state_next = CONNECTED;
        end
        default: begin
          state_next       = IDLE;
          m1_grant_next    = 1'b0;
          m2_grant_next    = 1'b0;
          bus_grant_next   = 2'b00;
          slave_grant_next = 3'b000;
        end
      endcase
    end

    busy_next = m1_grant_next | m2_grant_next;
  end

endmodule

// File: tb/tb_arbiter.sv
// tb/tb_arbiter.sv - randomized and directed bench for the bus arbiter
module tb_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m1_request = 1'b0;
  logic       m2_request = 1'b0;
  logic       slave_select = 1'b0;
  logic       m1_grant, m2_grant, busy;
  logic [1:0] bus_grant;
  logic [2:0] slave_grant;

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0 none / 1 / 2, bits_seen counts frame bits received.
  int       mdl_owner = 0;
  int       mdl_bits = 0;
  int       mdl_addr = 0;
  int       mdl_sg = 0;
  logic [7:0] obs, exp_vec;

  arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .m1_request   (m1_request),
    .m2_request   (m2_request),
    .slave_select (slave_select),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .busy         (busy),
    .bus_grant    (bus_grant),
    .slave_grant  (slave_grant)
  );

  always #5 clk = ~clk;

  assign obs = {m1_grant, m2_grant, busy, bus_grant, slave_grant};

  always_comb begin
    exp_vec = 8'd0;
    exp_vec[7]   = (mdl_owner == 1);
    exp_vec[6]   = (mdl_owner == 2);
    exp_vec[5]   = (mdl_owner != 0);
    exp_vec[4:3] = 2'(mdl_owner);
    exp_vec[2:0] = 3'(mdl_sg);
  end

  task automatic model_reset();
    mdl_owner = 0; mdl_bits = 0; mdl_addr = 0; mdl_sg = 0;
  endtask

  task automatic model_step(input logic r1, input logic r2, input logic ss);
    logic owner_req;
    if (mdl_owner == 0) begin
      mdl_sg = 0; mdl_bits = 0; mdl_addr = 0;
      if (r1) mdl_owner = 1;
      else if (r2) mdl_owner = 2;
    end else begin
      owner_req = (mdl_owner == 1) ? r1 : r2;
      if (!owner_req) begin
        model_reset();
      end else if (mdl_bits == 0) begin
        if (ss) mdl_bits = 1;
      end else if (mdl_bits == 1) begin
        mdl_addr = int'(ss); mdl_bits = 2;
      end else if (mdl_bits == 2) begin
        mdl_addr = mdl_addr + 2 * int'(ss);
        mdl_sg = (mdl_addr < 3) ? (1 << mdl_addr) : 0;
        mdl_bits = 3;
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    logic r1, r2, ss, rs;
    r1 = m1_request; r2 = m2_request; ss = slave_select; rs = reset;
    @(posedge clk);
    if (rs) model_reset();
    else model_step(r1, r2, ss);
    #1;
  endtask

  task automatic go_idle();
    m1_request = 0; m2_request = 0; slave_select = 0;
    cycle(); cycle();
  endtask

  task automatic test_reset();
    m1_request = 1; m2_request = 1;
    #2 reset = 1;
    #1 model_reset();
    checks++;
    if (obs !== 8'd0) begin
      failures++; $display("FAIL reset_immediate got=%b want=%b", obs, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs !== 8'd0) begin
        failures++; $display("FAIL reset_hold got=%b want=%b", obs, 8'd0);
      end
    end
    m1_request = 0; m2_request = 0;
    reset = 0;
    cycle();
  endtask

  task automatic test_m1_frame();
    logic frame [3] = '{1'b1, 1'b0, 1'b1};
    go_idle();
    m1_request = 1;
    cycle();
    checks++;
    if (obs !== 8'b1_0_1_01_000) begin
      failures++; $display("FAIL m1_grant got=%b want=%b", obs, 8'b1_0_1_01_000);
    end
    for (int i = 0; i < 3; i++) begin
      slave_select = frame[i];
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL m1_frame bit%0d got=%b want=%b", i, obs, exp_vec);
      end
    end
    slave_select = 0;
    checks++;
    if (slave_grant !== 3'b100) begin
      failures++; $display("FAIL m1_slave2 got=%b want=100", slave_grant);
    end
    m1_request = 0;
    cycle();
    checks++;
    if (obs !== 8'd0) begin
      failures++; $display("FAIL m1_release got=%b want=%b", obs, 8'd0);
    end
  endtask

  task automatic test_m2_frame();
    logic frame [3] = '{1'b1, 1'b1, 1'b0};
    go_idle();
    m2_request = 1;
    cycle();
    checks++;
    if (obs !== 8'b0_1_1_10_000) begin
      failures++; $display("FAIL m2_grant got=%b want=%b", obs, 8'b0_1_1_10_000);
    end
    for (int i = 0; i < 3; i++) begin
      slave_select = frame[i];
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      slave_select = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (obs !== 8'b0_1_1_10_010) begin
        failures++; $display("FAIL m2_slave1_hold got=%b want=%b", obs, 8'b0_1_1_10_010);
      end
    end
    go_idle();
  endtask

  task automatic test_both();
    logic frame [3] = '{1'b1, 1'b1, 1'b1};
    go_idle();
    m1_request = 1; m2_request = 1;
    cycle();
    checks++;
    if (obs !== 8'b1_0_1_01_000) begin
      failures++; $display("FAIL both_priority got=%b want=%b", obs, 8'b1_0_1_01_000);
    end
    for (int i = 0; i < 3; i++) begin
      slave_select = frame[i];
      cycle();
    end
    slave_select = 0;
    checks++;
    if (obs !== 8'b1_0_1_01_000) begin
      failures++; $display("FAIL both_addr3 got=%b want=%b", obs, 8'b1_0_1_01_000);
    end
    m1_request = 0;
    cycle();
    checks++;
    if (obs !== 8'd0) begin
      failures++; $display("FAIL both_idle_gap got=%b want=%b", obs, 8'd0);
    end
    cycle();
    checks++;
    if (obs !== 8'b0_1_1_10_000) begin
      failures++; $display("FAIL both_m2_after got=%b want=%b", obs, 8'b0_1_1_10_000);
    end
    go_idle();
  endtask

  task automatic test_no_preempt();
    go_idle();
    m2_request = 1;
    cycle();
    m1_request = 1;
    for (int i = 0; i < 5; i++) begin
      slave_select = (i == 0);
      cycle();
      checks++;
      if (m2_grant !== 1'b1 || m1_grant !== 1'b0 || obs !== exp_vec) begin
        failures++; $display("FAIL no_preempt got=%b want=%b", obs, exp_vec);
      end
    end
    slave_select = 0;
    m2_request = 0;
    cycle();
    cycle();
    checks++;
    if (obs !== 8'b1_0_1_01_000) begin
      failures++; $display("FAIL preempt_handover got=%b want=%b", obs, 8'b1_0_1_01_000);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic frame [3] = '{1'b0, 1'b1, 1'b0};
    go_idle();
    m1_request = 1;
    cycle();
    slave_select = 1; cycle();
    slave_select = 1; cycle();
    #2 reset = 1;
    #1 model_reset();
    checks++;
    if (obs !== 8'd0) begin
      failures++; $display("FAIL reset_mid got=%b want=%b", obs, 8'd0);
    end
    slave_select = 0;
    cycle();
    reset = 0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      slave_select = frame[i];
      cycle();
    end
    checks++;
    if (obs !== 8'b1_0_1_01_000) begin
      failures++; $display("FAIL reset_mid_newframe got=%b want=%b", obs, 8'b1_0_1_01_000);
    end
    slave_select = 0;
    cycle(); cycle();
    checks++;
    if (obs !== 8'b1_0_1_01_001) begin
      failures++; $display("FAIL reset_mid_slave0 got=%b want=%b", obs, 8'b1_0_1_01_001);
    end
    go_idle();
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) m1_request = ~m1_request;
      if ($urandom_range(0, 5) == 0) m2_request = ~m2_request;
      slave_select = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL random cyc%0d got=%b want=%b", i, obs, exp_vec);
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_m1_frame();
    test_m2_frame();
    test_both();
    test_no_preempt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
